// File: rtl/walk_phase_controller_pkg.sv
// -----------------------------------------------------------------------------
// walk_phase_controller_pkg
//   Shared definitions for the intersection sequencer: phase encodings,
//   light-head codes and the Moore output decode used by the top level.
// -----------------------------------------------------------------------------
package walk_phase_controller_pkg;

    typedef enum logic [2:0] {
        ST_MG     = 3'd0,
        ST_MG_EXT = 3'd1,
        ST_MY     = 3'd2,
        ST_WALK   = 3'd3,
        ST_SG     = 3'd4,
        ST_SG_EXT = 3'd5,
        ST_SY     = 3'd6
    } state_t;

    // Light-head codes, {R,Y,G}
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] main_lt;
        logic [2:0] side_lt;
        logic       walk;
    } lights_t;

    // Output pattern shown while in a given phase. Any code outside the
    // named phases shows the main-green pattern, matching where it recovers to.
    function automatic lights_t decode_lights(input state_t s);
        lights_t l;
        l = '{main_lt: LT_GRN, side_lt: LT_RED, walk: 1'b0};
        case (s)
            ST_MG, ST_MG_EXT: l = '{main_lt: LT_GRN, side_lt: LT_RED, walk: 1'b0};
            ST_MY:            l = '{main_lt: LT_YEL, side_lt: LT_RED, walk: 1'b0};
            ST_WALK:          l = '{main_lt: LT_RED, side_lt: LT_RED, walk: 1'b1};
            ST_SG, ST_SG_EXT: l = '{main_lt: LT_RED, side_lt: LT_GRN, walk: 1'b0};
            ST_SY:            l = '{main_lt: LT_RED, side_lt: LT_YEL, walk: 1'b0};
            default:          l = '{main_lt: LT_GRN, side_lt: LT_RED, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/walk_phase_controller_interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//   TW-bit down-counter measuring phase durations in ticks.
//   Ports:
//     clk       in   system clock
//     sys_reset in   asynchronous active-high reset (loads RST_VAL)
//     load      in   reload with load_val (has priority over counting)
//     load_val  in   TW-bit reload value (duration - 1)
//     tick_en   in   one-clk time-unit pulse; counting happens only on it
//     expired   out  count is zero and a tick is present this clk
// -----------------------------------------------------------------------------
module interval_timer #(
    parameter int unsigned      TW      = 4,
    parameter logic [TW-1:0]    RST_VAL = '0
) (
    input  logic          clk,
    input  logic          sys_reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick_en,
    output logic          expired
);

    logic [TW-1:0] r_count;

    assign expired = (r_count == '0) && tick_en;

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/walk_phase_controller.sv
// -----------------------------------------------------------------------------
// walk_phase_controller
//   Main/side intersection sequencer with an optional all-red walk phase
//   after main yellow when a pedestrian request is latched.
//   Ports:
//     clk                  in   system clock, rising edge
//     sys_reset            in   asynchronous active-high reset
//     tick_en              in   one-clk pulse per time unit
//     sensor_sync          in   synchronised side-street vehicle sensor
//     walkRegister_status  in   latched walk request
//     walkRegister_reset   out  one-clk clear pulse at walk-phase entry
//     main_light           out  main head {R,Y,G}, one-hot
//     side_light           out  side head {R,Y,G}, one-hot
//     walk_lamp            out  walk indicator
// -----------------------------------------------------------------------------
module walk_phase_controller
    import walk_phase_controller_pkg::*;
#(
    parameter int unsigned BASE_T = 6,
    parameter int unsigned EXT_T  = 3,
    parameter int unsigned YEL_T  = 2,
    parameter int unsigned WALK_T = 3,
    parameter int unsigned TW     = 4
) (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic       tick_en,
    input  logic       sensor_sync,
    input  logic       walkRegister_status,
    output logic       walkRegister_reset,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp
);

    localparam logic [TW-1:0] L_BASE = TW'(BASE_T - 1);
    localparam logic [TW-1:0] L_EXT  = TW'(EXT_T - 1);
    localparam logic [TW-1:0] L_YEL  = TW'(YEL_T - 1);
    localparam logic [TW-1:0] L_WALK = TW'(WALK_T - 1);

    state_t        r_state;
    lights_t       r_lights;
    logic          r_wr_reset;

    state_t        w_next;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_expired;

    interval_timer #(
        .TW      (TW),
        .RST_VAL (L_BASE)
    ) u_timer (
        .clk       (clk),
        .sys_reset (sys_reset),
        .load      (w_load),
        .load_val  (w_load_val),
        .tick_en   (tick_en),
        .expired   (w_expired)
    );

    // Next phase and timer reload. The sensor and the walk request only
    // matter in the expiry cycle; every transition reloads the timer with
    // the new phase's duration minus one.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = L_BASE;
        case (r_state)
            ST_MG: if (w_expired) begin
                w_load = 1'b1;
                if (sensor_sync) begin
                    w_next     = ST_MG_EXT;
                    w_load_val = L_EXT;
                end else begin
                    w_next     = ST_MY;
                    w_load_val = L_YEL;
                end
            end
            ST_MG_EXT: if (w_expired) begin
                w_load     = 1'b1;
                w_next     = ST_MY;
                w_load_val = L_YEL;
            end
            ST_MY: if (w_expired) begin
                w_load = 1'b1;
                if (walkRegister_status) begin
                    w_next     = ST_WALK;
                    w_load_val = L_WALK;
                end else begin
                    w_next     = ST_SG;
                    w_load_val = L_BASE;
                end
            end
            ST_WALK: if (w_expired) begin
                w_load     = 1'b1;
                w_next     = ST_SG;
                w_load_val = L_BASE;
            end
            ST_SG: if (w_expired) begin
                w_load = 1'b1;
                if (sensor_sync) begin
                    w_next     = ST_SG_EXT;
                    w_load_val = L_EXT;
                end else begin
                    w_next     = ST_SY;
                    w_load_val = L_YEL;
                end
            end
            ST_SG_EXT: if (w_expired) begin
                w_load     = 1'b1;
                w_next     = ST_SY;
                w_load_val = L_YEL;
            end
            ST_SY: if (w_expired) begin
                w_load     = 1'b1;
                w_next     = ST_MG;
                w_load_val = L_BASE;
            end
            default: begin
                // Illegal code: force back to main green on the next clk.
                w_load     = 1'b1;
                w_next     = ST_MG;
                w_load_val = L_BASE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they always
    // equal the decode of the current state, with no combinational glitches.
    // The walk-register clear fires only on the MY->WALK edge, so it lasts
    // exactly the first cycle of WALK.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state    <= ST_MG;
            r_lights   <= '{main_lt: LT_GRN, side_lt: LT_RED, walk: 1'b0};
            r_wr_reset <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_lights   <= decode_lights(w_next);
            r_wr_reset <= (r_state == ST_MY) && (w_next == ST_WALK);
        end
    end

    assign main_light         = r_lights.main_lt;
    assign side_light         = r_lights.side_lt;
    assign walk_lamp          = r_lights.walk;
    assign walkRegister_reset = r_wr_reset;

endmodule

// File: tb/tb_walk_phase_controller.sv
module tb_walk_phase_controller;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic       tick_en;
    logic       sensor_sync;
    logic       walkRegister_status;
    logic       walkRegister_reset;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;

    int checks   = 0;
    int failures = 0;

    walk_phase_controller dut (
        .clk                 (clk),
        .sys_reset           (sys_reset),
        .tick_en             (tick_en),
        .sensor_sync         (sensor_sync),
        .walkRegister_status (walkRegister_status),
        .walkRegister_reset  (walkRegister_reset),
        .main_light          (main_light),
        .side_light          (side_light),
        .walk_lamp           (walk_lamp)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // A phase is a name plus a number of ticks left to show it.
    localparam int PH_MAIN_GO   = 11;
    localparam int PH_MAIN_MORE = 12;
    localparam int PH_MAIN_YEL  = 13;
    localparam int PH_PED       = 14;
    localparam int PH_SIDE_GO   = 15;
    localparam int PH_SIDE_MORE = 16;
    localparam int PH_SIDE_YEL  = 17;

    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    int m_phase;
    int m_left;
    bit m_clear;

    function automatic int dur(input int p);
        case (p)
            PH_MAIN_GO, PH_SIDE_GO:     return 6;
            PH_MAIN_MORE, PH_SIDE_MORE: return 3;
            PH_MAIN_YEL, PH_SIDE_YEL:   return 2;
            default:                    return 3;
        endcase
    endfunction

    function automatic logic [2:0] exp_main(input int p);
        if (p == PH_MAIN_GO || p == PH_MAIN_MORE) return GRN;
        if (p == PH_MAIN_YEL) return YEL;
        return RED;
    endfunction

    function automatic logic [2:0] exp_side(input int p);
        if (p == PH_SIDE_GO || p == PH_SIDE_MORE) return GRN;
        if (p == PH_SIDE_YEL) return YEL;
        return RED;
    endfunction

    task automatic model_reset();
        m_phase = PH_MAIN_GO;
        m_left  = dur(PH_MAIN_GO);
        m_clear = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        int nxt;
        m_clear = 1'b0;
        if (!tick_en) return;
        if (m_left > 1) begin
            m_left = m_left - 1;
            return;
        end
        case (m_phase)
            PH_MAIN_GO:   nxt = sensor_sync ? PH_MAIN_MORE : PH_MAIN_YEL;
            PH_MAIN_MORE: nxt = PH_MAIN_YEL;
            PH_MAIN_YEL:  nxt = walkRegister_status ? PH_PED : PH_SIDE_GO;
            PH_PED:       nxt = PH_SIDE_GO;
            PH_SIDE_GO:   nxt = sensor_sync ? PH_SIDE_MORE : PH_SIDE_YEL;
            PH_SIDE_MORE: nxt = PH_SIDE_YEL;
            default:      nxt = PH_MAIN_GO;
        endcase
        m_clear = (nxt == PH_PED);
        m_phase = nxt;
        m_left  = dur(nxt);
    endtask

    // Drive inputs for the coming edge, take the edge, settle 1 time unit.
    task automatic advance(input logic s, input logic w, input logic t);
        sensor_sync         = s;
        walkRegister_status = w;
        tick_en             = t;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        sys_reset = 1'b1;
        @(posedge clk);
        #1;
        sys_reset = 1'b0;
        model_reset();
    endtask

    // ---------------- always-on safety monitor ----------------
    always @(negedge clk) begin
        checks++;
        if ($countones(main_light) != 1 || $countones(side_light) != 1) begin
            failures++;
            $display("FAIL onehot main=%b side=%b", main_light, side_light);
        end
        checks++;
        if (main_light != RED && side_light != RED) begin
            failures++;
            $display("FAIL conflict main=%b side=%b both non-red", main_light, side_light);
        end
        checks++;
        if (walk_lamp && (main_light != RED || side_light != RED)) begin
            failures++;
            $display("FAIL walk_red main=%b side=%b walk=1", main_light, side_light);
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_reset = 1'b1; tick_en = 1'b1; sensor_sync = 1'b0; walkRegister_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({main_light, side_light, walk_lamp, walkRegister_reset} !== {GRN, RED, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got main=%b side=%b walk=%b clr=%b need 001 100 0 0",
                     main_light, side_light, walk_lamp, walkRegister_reset);
        end
        sys_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_plain_cycle();
        int mg = 0, my = 0, sg = 0, sy = 0, clr = 0;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            advance(1'b0, 1'b0, 1'b1);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL plain_cycle[%0d] got %b %b %b %b need %b %b %b %b", i,
                         main_light, side_light, walk_lamp, walkRegister_reset,
                         exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear);
            end
            if (i < 16) begin
                mg += (main_light == GRN); my += (main_light == YEL);
                sg += (side_light == GRN); sy += (side_light == YEL);
            end
            clr += walkRegister_reset;
        end
        checks++;
        if ({mg, my, sg, sy, clr} !== {32'd6, 32'd2, 32'd6, 32'd2, 32'd0}) begin
            failures++;
            $display("FAIL plain_period got MG=%0d MY=%0d SG=%0d SY=%0d clr=%0d need 6 2 6 2 0",
                     mg, my, sg, sy, clr);
        end
    endtask

    task automatic test_sensor_ext();
        int mg = 0, sg = 0, my = 0, sy = 0;
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            advance(1'b1, 1'b0, 1'b1);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL sensor_ext[%0d] got %b %b %b %b need %b %b", i,
                         main_light, side_light, walk_lamp, walkRegister_reset,
                         exp_main(m_phase), exp_side(m_phase));
            end
            mg += (main_light == GRN); sg += (side_light == GRN);
            my += (main_light == YEL); sy += (side_light == YEL);
        end
        checks++;
        if ({mg, sg, my, sy} !== {32'd9, 32'd9, 32'd2, 32'd2}) begin
            failures++;
            $display("FAIL sensor_period got MG=%0d SG=%0d MY=%0d SY=%0d need 9 9 2 2", mg, sg, my, sy);
        end
    endtask

    task automatic test_walk_phase();
        int walks = 0, clrs = 0, bad_clr = 0;
        logic prev_walk = 1'b0;
        apply_reset();
        for (int i = 0; i < 19; i++) begin
            advance(1'b0, 1'b1, 1'b1);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL walk_phase[%0d] got %b %b %b %b need %b %b %b %b", i,
                         main_light, side_light, walk_lamp, walkRegister_reset,
                         exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear);
            end
            walks += walk_lamp;
            clrs  += walkRegister_reset;
            if (walkRegister_reset && !(walk_lamp && !prev_walk)) bad_clr++;
            prev_walk = walk_lamp;
        end
        checks++;
        if ({walks, clrs, bad_clr} !== {32'd3, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL walk_counts got walk=%0d clr=%0d misplaced=%0d need 3 1 0", walks, clrs, bad_clr);
        end
    endtask

    task automatic test_walk_dropped();
        int walks = 0;
        logic req;
        apply_reset();
        // Request visible only while in the main extension, then gone.
        for (int i = 0; i < 22; i++) begin
            req = (m_phase == PH_MAIN_MORE);
            advance(1'b1, req, 1'b1);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL walk_drop[%0d] got %b %b %b %b need %b %b", i,
                         main_light, side_light, walk_lamp, walkRegister_reset,
                         exp_main(m_phase), exp_side(m_phase));
            end
            walks += walk_lamp;
        end
        checks++;
        if (walks !== 0) begin
            failures++;
            $display("FAIL walk_drop_count got walk=%0d need 0", walks);
        end
        // Request raised in the extension and held through yellow expiry.
        walks = 0;
        for (int i = 0; i < 25; i++) begin
            req = (m_phase == PH_MAIN_MORE || m_phase == PH_MAIN_YEL);
            advance(1'b1, req, 1'b1);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL walk_hold[%0d] got %b %b %b %b need %b %b", i,
                         main_light, side_light, walk_lamp, walkRegister_reset,
                         exp_main(m_phase), exp_side(m_phase));
            end
            walks += walk_lamp;
        end
        checks++;
        if (walks !== 3) begin
            failures++;
            $display("FAIL walk_hold_count got walk=%0d need 3", walks);
        end
    endtask

    task automatic test_async_reset();
        int  guard = 0;
        int  mg = 0;
        logic ylw6 = 1'b0;
        apply_reset();
        while (!walk_lamp && guard < 40) begin
            advance(1'b0, 1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (!walk_lamp) begin
            failures++;
            $display("FAIL async_reach_walk got walk=%b need 1 within 40 clk", walk_lamp);
        end
        #2 sys_reset = 1'b1;
        #1;
        checks++;
        if ({main_light, side_light, walk_lamp, walkRegister_reset} !== {GRN, RED, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got %b %b %b %b need 001 100 0 0",
                     main_light, side_light, walk_lamp, walkRegister_reset);
        end
        #2 sys_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            advance(1'b0, 1'b0, 1'b1);
            checks++;
            if ({main_light, side_light, walk_lamp} !== {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED}) begin
                failures++;
                $display("FAIL async_restart[%0d] got %b %b %b need %b %b", i,
                         main_light, side_light, walk_lamp, exp_main(m_phase), exp_side(m_phase));
            end
            mg += (main_light == GRN);
            if (i == 5) ylw6 = (main_light == YEL);
        end
        checks++;
        if ({mg, ylw6} !== {32'd5, 1'b1}) begin
            failures++;
            $display("FAIL async_restart_mg got green_samples=%0d yellow_at_6=%b need 5 1", mg, ylw6);
        end
    endtask

    task automatic test_slow_tick();
        int mg = 0, moved_off_tick = 0;
        logic [6:0] prev;
        logic t;
        apply_reset();
        prev = {main_light, side_light, walk_lamp};
        for (int i = 0; i < 128; i++) begin
            t = (i % 4 == 0);
            advance(1'b0, 1'b0, t);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL slow_tick[%0d] got %b %b need %b %b", i,
                         main_light, side_light, exp_main(m_phase), exp_side(m_phase));
            end
            if (!t && {main_light, side_light, walk_lamp} != prev) moved_off_tick++;
            prev = {main_light, side_light, walk_lamp};
            if (i < 64) mg += (main_light == GRN);
        end
        checks++;
        if ({mg, moved_off_tick} !== {32'd24, 32'd0}) begin
            failures++;
            $display("FAIL slow_tick_period got MG=%0d off_tick_moves=%0d need 24 0", mg, moved_off_tick);
        end
    endtask

    task automatic test_random();
        logic s, w, t;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            s = $urandom_range(0, 1);
            w = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 3) != 0);
            advance(s, w, t);
            checks++;
            if ({main_light, side_light, walk_lamp, walkRegister_reset} !==
                {exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear}) begin
                failures++;
                $display("FAIL random[%0d] got %b %b %b %b need %b %b %b %b", i,
                         main_light, side_light, walk_lamp, walkRegister_reset,
                         exp_main(m_phase), exp_side(m_phase), m_phase == PH_PED, m_clear);
            end
        end
    endtask

    initial begin
        sys_reset = 1'b1;
        tick_en = 1'b1;
        sensor_sync = 1'b0;
        walkRegister_status = 1'b0;
        model_reset();
        test_reset();
        test_plain_cycle();
        test_sensor_ext();
        test_walk_phase();
        test_walk_dropped();
        test_async_reset();
        test_slow_tick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
